spi_slave_receiver: RTL and testbench

SPI slave receive-only block. It samples an asynchronous SPI bus (ss, sclk, sdi) in the system clock domain and assembles a bitcount-wide word. It presents the word with a one-cycle valid strobe. It sits behind board-level SPI pins and feeds parallel data to downstream logic.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_slave_receiver_if.sv | 26 ++
 rtl/spi_input_sync.sv | 40 ++++
 rtl/spi_slave_receiver.sv | 158 +++++++++++++++
 tb/tb_spi_slave_receiver.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave receiver.
//   state_e        : frame FSM states (IDLE, RECEIVE, DONE)
//   leading_edge   : sclk leaving its idle level, selected by CPOL
//   trailing_edge  : sclk returning to its idle level, selected by CPOL
//   sample_edge    : edge on which sdi is captured, selected by CPOL/CPHA
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Leading edge: idle-low clock rises, idle-high clock falls.
  function automatic logic leading_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

  // Trailing edge: the return to the idle level.
  function automatic logic trailing_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? rise : fall;
  endfunction

  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  function automatic logic sample_edge(input logic cpol, input logic cpha,
                                       input logic rise, input logic fall);
    return cpha ? trailing_edge(cpol, rise, fall) : leading_edge(cpol, rise, fall);
  endfunction

endpackage

// File: rtl/spi_slave_receiver_if.sv
// Bus bundle between an SPI master-side driver and the slave receiver.
//   ss, sclk, sdi : asynchronous SPI pins
//   trigger       : publish request (system clock domain)
//   data, valid   : received word and its one-cycle strobe
interface spi_slave_receiver_if #(
  parameter int unsigned bitcount = 8
);

  logic                ss;
  logic                sclk;
  logic                sdi;
  logic                trigger;
  logic [bitcount-1:0] data;
  logic                valid;

  modport master (
    output ss, sclk, sdi, trigger,
    input  data, valid
  );

  modport slave (
    input  ss, sclk, sdi, trigger,
    output data, valid
  );

endinterface

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser for one asynchronous input, plus edge pulses.
//   clock, reset_n : system clock, async active-low reset
//   din            : asynchronous input
//   sync           : synchronised level (registered)
//   rise_c, fall_c : one-cycle pulses on synchronised 0->1 / 1->0 transitions
// reset_value sets the level the whole chain assumes during reset, so no
// edge is reported at reset release unless the input really differs.
module spi_input_sync #(
  parameter logic reset_value = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= reset_value;
      sync_q <= reset_value;
      prev_q <= reset_value;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync   = sync_q;
  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_receiver.sv
// Receive-only SPI slave. Oversamples ss/sclk/sdi in the system clock domain,
// assembles a bitcount-wide word and publishes it with a one-cycle valid.
//   clock, reset_n : system clock (>= 4x sclk), async active-low reset
//   bus.ss/sclk/sdi: asynchronous SPI inputs
//   bus.trigger    : publish request, used only with use_external_trigger=1
//   bus.data       : received word (zero outside valid when gated)
//   bus.valid      : one-cycle strobe for a new word
module spi_slave_receiver
  import spi_pkg::*;
#(
  parameter int unsigned bitcount             = 8,
  parameter logic        ss_polarity          = 1'b1,
  parameter logic        sclk_polarity        = 1'b0,
  parameter logic        sclk_phase           = 1'b1,
  parameter logic        msb_first            = 1'b1,
  parameter logic        use_gated_output     = 1'b1,
  parameter logic        use_external_trigger = 1'b0
) (
  input logic            clock,
  input logic            reset_n,
  spi_slave_receiver_if.slave bus
);

  localparam int unsigned cnt_w = $clog2(bitcount + 1);

  logic ss_sync, ss_rise_c, ss_fall_c;
  logic sclk_sync, sclk_rise_c, sclk_fall_c;
  logic sdi_sync, sdi_rise_c, sdi_fall_c;

  spi_input_sync #(.reset_value(~ss_polarity)) u_ss_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (bus.ss),
    .sync    (ss_sync),
    .rise_c  (ss_rise_c),
    .fall_c  (ss_fall_c)
  );

  spi_input_sync #(.reset_value(sclk_polarity)) u_sclk_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (bus.sclk),
    .sync    (sclk_sync),
    .rise_c  (sclk_rise_c),
    .fall_c  (sclk_fall_c)
  );

  // Same latency as sclk so each sample edge sees the matching data bit.
  spi_input_sync #(.reset_value(1'b0)) u_sdi_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (bus.sdi),
    .sync    (sdi_sync),
    .rise_c  (sdi_rise_c),
    .fall_c  (sdi_fall_c)
  );

  logic sync_unused;
  assign sync_unused = sclk_sync ^ sdi_rise_c ^ sdi_fall_c;

  state_e              state_q;
  logic [cnt_w-1:0]    cnt_q;
  logic [bitcount-1:0] shift_q;
  logic [bitcount-1:0] pend_q;
  logic                pend_valid_q;
  logic [bitcount-1:0] data_q;
  logic                valid_q;
  logic [1:0]          prime_q;
  logic                armed_q;

  logic                ss_act_c;
  logic                ss_start_c;
  logic                ss_stop_c;
  logic                sample_c;
  logic                word_done_c;
  logic                prime_done_c;
  logic [bitcount-1:0] next_shift_c;

  assign ss_act_c     = (ss_sync == ss_polarity);
  assign prime_done_c = (prime_q == 2'd2);
  // A frame only starts once ss has been seen inactive after reset, so an ss
  // held active across reset release cannot open a frame mid-stream.
  assign ss_start_c   = (ss_polarity ? ss_rise_c : ss_fall_c) & armed_q;
  assign ss_stop_c    = ss_polarity ? ss_fall_c : ss_rise_c;
  assign sample_c     = sample_edge(sclk_polarity, sclk_phase, sclk_rise_c, sclk_fall_c);
  // All bits captured; still honoured if ss drops in this very cycle.
  assign word_done_c  = (state_q == RECEIVE) && (cnt_q == cnt_w'(bitcount));
  assign next_shift_c = msb_first ? {shift_q[bitcount-2:0], sdi_sync}
                                  : {sdi_sync, shift_q[bitcount-1:1]};

  // Frame FSM, shift register, pending word and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      prime_q      <= 2'd0;
      armed_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (use_gated_output) begin
        data_q <= '0;
      end

      if (!prime_done_c) begin
        prime_q <= prime_q + 2'd1;
      end
      if (prime_done_c && !ss_act_c) begin
        armed_q <= 1'b1;
      end

      // Frame start wins over a coincident sample edge.
      if (ss_start_c) begin
        state_q <= RECEIVE;
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (ss_stop_c) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          RECEIVE: begin
            if (cnt_q == cnt_w'(bitcount)) begin
              state_q <= DONE;
            end else if (sample_c) begin
              shift_q <= next_shift_c;
              cnt_q   <= cnt_q + cnt_w'(1);
            end
          end
          default: ;
        endcase
      end

      if (use_external_trigger) begin
        // Publish the older pending word first; a new word then replaces it.
        if (bus.trigger && pend_valid_q) begin
          data_q       <= pend_q;
          valid_q      <= 1'b1;
          pend_valid_q <= 1'b0;
        end
        if (word_done_c) begin
          pend_q       <= shift_q;
          pend_valid_q <= 1'b1;
        end
      end else if (word_done_c) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Self-checking bench for spi_slave_receiver: five configurations share one
// SPI master (mode 0/1 timing); table vectors, hand sequences and random frames.
module tb_spi_slave_receiver;

  localparam int n_dut = 5;
  localparam int half  = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic ss      = 1'b0;
  logic sclk    = 1'b0;
  logic sdi     = 1'b0;
  logic trigger = 1'b0;

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  spi_slave_receiver_if #(.bitcount(8)) if_a ();
  spi_slave_receiver_if #(.bitcount(8)) if_b ();
  spi_slave_receiver_if #(.bitcount(8)) if_c ();
  spi_slave_receiver_if #(.bitcount(8)) if_d ();
  spi_slave_receiver_if #(.bitcount(8)) if_e ();

  assign if_a.ss = ss;  assign if_a.sclk = sclk;  assign if_a.sdi = sdi;  assign if_a.trigger = trigger;
  assign if_b.ss = ss;  assign if_b.sclk = sclk;  assign if_b.sdi = sdi;  assign if_b.trigger = trigger;
  assign if_c.ss = ss;  assign if_c.sclk = sclk;  assign if_c.sdi = sdi;  assign if_c.trigger = trigger;
  assign if_d.ss = ss;  assign if_d.sclk = sclk;  assign if_d.sdi = sdi;  assign if_d.trigger = trigger;
  // Inverted ss and sclk: active-low select, idle-high clock, still trailing-edge sampling.
  assign if_e.ss = ~ss; assign if_e.sclk = ~sclk; assign if_e.sdi = sdi;  assign if_e.trigger = trigger;

  spi_slave_receiver u_a (.clock(clock), .reset_n(reset_n), .bus(if_a));
  spi_slave_receiver #(.msb_first(1'b0)) u_b (.clock(clock), .reset_n(reset_n), .bus(if_b));
  spi_slave_receiver #(.use_gated_output(1'b0)) u_c (.clock(clock), .reset_n(reset_n), .bus(if_c));
  spi_slave_receiver #(.use_external_trigger(1'b1)) u_d (.clock(clock), .reset_n(reset_n), .bus(if_d));
  spi_slave_receiver #(.ss_polarity(1'b0), .sclk_polarity(1'b1), .sclk_phase(1'b1))
    u_e (.clock(clock), .reset_n(reset_n), .bus(if_e));

  logic       vld [n_dut];
  logic [7:0] dat [n_dut];
  assign vld[0] = if_a.valid; assign dat[0] = if_a.data;
  assign vld[1] = if_b.valid; assign dat[1] = if_b.data;
  assign vld[2] = if_c.valid; assign dat[2] = if_c.data;
  assign vld[3] = if_d.valid; assign dat[3] = if_d.data;
  assign vld[4] = if_e.valid; assign dat[4] = if_e.data;

  int         pulses   [n_dut];
  logic [7:0] got      [n_dut];
  logic       last_vld [n_dut];
  logic [7:0] last_dat [n_dut];

  // Reference state: non-gated output and pending word of the triggered unit.
  logic [7:0] last_c;
  logic       pend_has;
  logic [7:0] pend_word;

  typedef struct {
    string       name;
    logic [15:0] seq;      // bit i is the i-th bit on the wire
    int          n;
    logic [7:0]  exp_msb;
    logic [7:0]  exp_lsb;
    int          exp_pulse;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One system cycle: observe outputs on the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clock);
    for (int i = 0; i < n_dut; i++) begin
      last_vld[i] = vld[i];
      last_dat[i] = dat[i];
      if (vld[i]) begin
        pulses[i]++;
        got[i] = dat[i];
      end
      if (i != 2 && !vld[i]) chk($sformatf("gate%0d", i), int'(dat[i]), 0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send_bits(input logic [15:0] seq, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      sclk = 1'b1;
      sdi  = seq[i];
      ticks(half);
      sclk = 1'b0;
      ticks(half);
    end
  endtask

  task automatic frame(input logic [15:0] seq, input int n);
    ss = 1'b1;
    ticks(4);
    send_bits(seq, 0, n);
    ticks(6);
    ss = 1'b0;
    ticks(6);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    ticks(3);
  endtask

  // Word as the wire order defines it: first bit is the MSB or the LSB.
  function automatic logic [7:0] model_word(input logic [15:0] seq, input bit lsb_first);
    int w = 0;
    for (int i = 0; i < 8; i++) begin
      if (seq[i]) w += lsb_first ? (1 << i) : (1 << (7 - i));
    end
    return 8'(w);
  endfunction

  task automatic run_frame(input string name, input logic [15:0] seq, input int n,
                           input logic [7:0] exp_msb, input logic [7:0] exp_lsb,
                           input int exp_pulse, input bit do_trig);
    int p0 [n_dut];
    p0 = pulses;
    frame(seq, n);
    chk({name, "_pa"}, pulses[0] - p0[0], exp_pulse);
    chk({name, "_pb"}, pulses[1] - p0[1], exp_pulse);
    chk({name, "_pc"}, pulses[2] - p0[2], exp_pulse);
    chk({name, "_pd"}, pulses[3] - p0[3], 0);
    chk({name, "_pe"}, pulses[4] - p0[4], exp_pulse);
    if (exp_pulse != 0) begin
      chk({name, "_da"}, int'(got[0]), int'(exp_msb));
      chk({name, "_db"}, int'(got[1]), int'(exp_lsb));
      chk({name, "_de"}, int'(got[4]), int'(exp_msb));
      last_c    = exp_msb;
      pend_has  = 1'b1;
      pend_word = exp_msb;
    end
    chk({name, "_hold_c"}, int'(last_dat[2]), int'(last_c));
    if (do_trig) begin
      ticks(10);
      p0 = pulses;
      pulse_trigger();
      chk({name, "_trig_pd"}, pulses[3] - p0[3], pend_has ? 1 : 0);
      if (pend_has) chk({name, "_trig_dd"}, int'(got[3]), int'(pend_word));
      pend_has = 1'b0;
    end
  endtask

  initial begin
    int p0 [n_dut];
    logic [15:0] rseq;
    int rn;
    bit rtrig;
    logic [7:0] wm, wl;

    for (int i = 0; i < n_dut; i++) begin
      pulses[i] = 0;
      got[i]    = 8'h00;
    end
    last_c    = 8'h00;
    pend_has  = 1'b0;
    pend_word = 8'h00;

    vecs[0] = '{"ones",    16'h00FF, 8,  8'hFF, 8'hFF, 1};
    vecs[1] = '{"zeros",   16'h0000, 8,  8'h00, 8'h00, 1};
    vecs[2] = '{"a5",      16'h00A5, 8,  8'hA5, 8'hA5, 1};
    vecs[3] = '{"c0",      16'h0003, 8,  8'hC0, 8'h03, 1};
    vecs[4] = '{"abort5",  16'h001F, 5,  8'h00, 8'h00, 0};
    vecs[5] = '{"extra10", 16'h0307, 10, 8'hE0, 8'h07, 1};
    vecs[6] = '{"5a",      16'h005A, 8,  8'h5A, 8'h5A, 1};

    // Reset state.
    #1 reset_n = 1'b0;
    tick();
    for (int i = 0; i < n_dut; i++) begin
      chk($sformatf("rst_valid%0d", i), int'(vld[i]), 0);
      chk($sformatf("rst_data%0d", i), int'(dat[i]), 0);
    end
    ticks(2);
    reset_n = 1'b1;
    ticks(5);

    // Table-driven frames.
    foreach (vecs[v]) begin
      run_frame(vecs[v].name, vecs[v].seq, vecs[v].n, vecs[v].exp_msb,
                vecs[v].exp_lsb, vecs[v].exp_pulse, 1'b1);
    end

    // Deferred publish: valid only on the cycle after trigger is seen.
    p0 = pulses;
    frame(16'h005A, 8);
    ticks(10);
    chk("trig_nopulse_before", pulses[3] - p0[3], 0);
    trigger = 1'b1;
    tick();
    chk("trig_valid_early", int'(last_vld[3]), 0);
    trigger = 1'b0;
    tick();
    chk("trig_valid", int'(last_vld[3]), 1);
    chk("trig_data", int'(last_dat[3]), 8'h5A);
    tick();
    chk("trig_valid_after", int'(last_vld[3]), 0);
    chk("trig_data_after", int'(last_dat[3]), 0);
    chk("trig_count", pulses[3] - p0[3], 1);
    last_c = 8'h5A;

    // Newer word overwrites an unpublished one.
    p0 = pulses;
    frame(16'h0003, 8);
    frame(16'h00FF, 8);
    ticks(5);
    pulse_trigger();
    chk("ovw_count", pulses[3] - p0[3], 1);
    chk("ovw_data", int'(got[3]), 8'hFF);
    last_c = 8'hFF;

    // Reset in the middle of a frame, ss held active across reset release.
    ss = 1'b1;
    ticks(4);
    send_bits(16'h00F0, 0, 4);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < n_dut; i++) begin
      chk($sformatf("midrst_valid%0d", i), int'(vld[i]), 0);
      chk($sformatf("midrst_data%0d", i), int'(dat[i]), 0);
    end
    tick();
    ticks(2);
    reset_n = 1'b1;
    last_c   = 8'h00;
    pend_has = 1'b0;
    p0 = pulses;
    send_bits(16'h00F0, 4, 4);
    ticks(6);
    chk("midrst_no_pulse", pulses[0] - p0[0], 0);
    chk("midrst_c_zero", int'(last_dat[2]), 0);
    ss = 1'b0;
    ticks(6);
    run_frame("after_rst", 16'h003C, 8, 8'h3C, 8'h3C, 1, 1'b1);

    // Random frames against the wire-order model.
    for (int r = 0; r < 25; r++) begin
      rseq  = 16'($urandom);
      rn    = int'($urandom_range(5, 10));
      rtrig = 1'($urandom_range(0, 1));
      wm    = model_word(rseq, 1'b0);
      wl    = model_word(rseq, 1'b1);
      run_frame($sformatf("rnd%0d", r), rseq, rn, wm, wl, (rn >= 8) ? 1 : 0, rtrig);
      ticks(int'($urandom_range(0, 5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
